// File: rtl/encap_uart_dump.sv
// Streams the encapsulation results (C0, then C1, then K) to a byte-wide UART, each word LSB first.
// Define ENCAP_DUMP_HEADER_EN to prefix each section with a one-byte tag (0xC0, 0xC1, 0x4B).
module encap_uart_dump #(
  parameter int C0_WORDS = 24,
  parameter int C0_AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             finished,
  output logic             rd_C0,
  output logic [C0_AW-1:0] C0_addr,
  input  logic [31:0]      C0_out,
  output logic             rd_C1,
  output logic [2:0]       C1_addr,
  input  logic [31:0]      C1_out,
  output logic             rd_K,
  output logic [2:0]       K_addr,
  input  logic [31:0]      K_out,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  input  logic             tx_done
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, LATCH, SEND, WAIT_TX, NEXT} state_t;

  state_t      state;
  logic [1:0]  sec;        // 0 = C0, 1 = C1, 2 = K
  logic [31:0] word;
  logic [1:0]  byte_idx;
  logic [31:0] cur_out;
  logic        last_word;
  logic [1:0]  next_idx;
  logic [7:0]  next_byte;

`ifdef ENCAP_DUMP_HEADER_EN
  logic tag_phase;

  function automatic logic [7:0] tag_of(input logic [1:0] s);
    case (s)
      2'd0:    return 8'hC0;
      2'd1:    return 8'hC1;
      default: return 8'h4B;
    endcase
  endfunction
`endif

  always_comb begin
    cur_out   = K_out;
    last_word = (K_addr == 3'd7);
    case (sec)
      2'd0: begin
        cur_out   = C0_out;
        last_word = (C0_addr == C0_AW'(C0_WORDS - 1));
      end
      2'd1: begin
        cur_out   = C1_out;
        last_word = (C1_addr == 3'd7);
      end
      default: ;
    endcase
  end

  assign next_idx  = byte_idx + 2'd1;
  assign next_byte = word[{next_idx, 3'b000} +: 8];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sec      <= 2'd0;
      busy     <= 1'b0;
      finished <= 1'b0;
      rd_C0    <= 1'b0;
      rd_C1    <= 1'b0;
      rd_K     <= 1'b0;
      C0_addr  <= '0;
      C1_addr  <= '0;
      K_addr   <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      word     <= '0;
      byte_idx <= '0;
`ifdef ENCAP_DUMP_HEADER_EN
      tag_phase <= 1'b0;
`endif
    end else begin
      // Strobes and pulses default low; each is raised for exactly one cycle.
      finished <= 1'b0;
      tx_start <= 1'b0;
      rd_C0    <= 1'b0;
      rd_C1    <= 1'b0;
      rd_K     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            sec  <= 2'd0;
`ifdef ENCAP_DUMP_HEADER_EN
            state     <= SEND;
            tx_start  <= 1'b1;
            tx_data   <= tag_of(2'd0);
            tag_phase <= 1'b1;
`else
            state <= READ;
            rd_C0 <= 1'b1;
`endif
          end
        end
        READ:  state <= WAIT;
        WAIT:  state <= LATCH;
        LATCH: begin
          word     <= cur_out;
          byte_idx <= 2'd0;
          tx_data  <= cur_out[7:0];
          tx_start <= 1'b1;
          state    <= SEND;
        end
        SEND: state <= WAIT_TX;
        WAIT_TX: begin
          if (tx_done) begin
`ifdef ENCAP_DUMP_HEADER_EN
            if (tag_phase) begin
              tag_phase <= 1'b0;
              state     <= READ;
              rd_C0     <= (sec == 2'd0);
              rd_C1     <= (sec == 2'd1);
              rd_K      <= (sec == 2'd2);
            end else
`endif
            if (byte_idx != 2'd3) begin
              byte_idx <= next_idx;
              tx_data  <= next_byte;
              tx_start <= 1'b1;
              state    <= SEND;
            end else begin
              state <= NEXT;
            end
          end
        end
        NEXT: begin
          if (last_word) begin
            case (sec)
              2'd0:    C0_addr <= '0;
              2'd1:    C1_addr <= '0;
              default: K_addr  <= '0;
            endcase
            if (sec == 2'd2) begin
              sec      <= 2'd0;
              busy     <= 1'b0;
              finished <= 1'b1;
              state    <= IDLE;
            end else begin
              sec <= sec + 2'd1;
`ifdef ENCAP_DUMP_HEADER_EN
              state     <= SEND;
              tx_start  <= 1'b1;
              tx_data   <= tag_of(sec + 2'd1);
              tag_phase <= 1'b1;
`else
              state <= READ;
              rd_C1 <= (sec == 2'd0);
              rd_K  <= (sec == 2'd1);
`endif
            end
          end else begin
            case (sec)
              2'd0:    C0_addr <= C0_addr + C0_AW'(1);
              2'd1:    C1_addr <= C1_addr + 3'd1;
              default: K_addr  <= K_addr + 3'd1;
            endcase
            state <= READ;
            rd_C0 <= (sec == 2'd0);
            rd_C1 <= (sec == 2'd1);
            rd_K  <= (sec == 2'd2);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
